// File: rtl/paicore_rx_pkg.sv
// Shared types and constants for the PAICORE receive merge path.
// The channel FSM state, the FIFO depth and the beat that closes a transfer on idle timeout.
package paicore_rx_pkg;

  localparam int WORD_W     = 32;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE,
    ACKED
  } ch_state_e;

  localparam logic [2*WORD_W-1:0] TERM_BEAT = {(2*WORD_W){1'b1}};

endpackage

// File: rtl/paicore_recv_merge_if.sv
// Chip-side request/acknowledge bundle plus the merged AXI-Stream output.
// The master modport is the receiver's view; the slave modport is the chip and the stream sink together.
interface paicore_recv_merge_if
  import paicore_rx_pkg::*;
#(
  parameter int Channel    = 4,
  parameter int DATA_WIDTH = 64
);

  logic [Channel-1:0]        request;
  logic [Channel*WORD_W-1:0] din;
  logic [Channel-1:0]        acknowledge;
  logic                      m_axis_tready;
  logic [DATA_WIDTH-1:0]     m_axis_tdata;
  logic                      m_axis_tlast;
  logic                      m_axis_tvalid;

  modport master (
    input  request, din, m_axis_tready,
    output acknowledge, m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output request, din, m_axis_tready,
    input  acknowledge, m_axis_tdata, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/paicore_rx_hs_channel.sv
// One chip channel: request synchronizer, 4-phase handshake FSM, word-pair packer and 2-entry beat FIFO.
// Ack rises 1 clk after the synchronized request; a full FIFO withholds ack, which is the only chip backpressure.
module paicore_rx_hs_channel
  import paicore_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  request,
  input  logic [WORD_W-1:0]     din,
  output logic                  acknowledge,
  input  logic                  pop,
  input  logic                  drop,
  output logic                  vld,
  output logic [2*WORD_W-1:0]   dat,
  output logic                  busy,
  output logic                  lone
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  ch_state_e              state_q, state_d;
  logic                   sel_q;
  logic [WORD_W-1:0]      word0_q, word1_q;
  logic [2*WORD_W-1:0]    mem_q [FIFO_DEPTH];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             cnt_q;
  logic                   full, accept, release_hs, push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= request;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (cnt_q == 2'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    release_hs = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && en && !full) begin
          accept  = 1'b1;
          state_d = ACKED;
        end
      end
      ACKED: begin
        // ien is not consulted here so a started handshake always returns to zero
        if (!req_s) begin
          release_hs = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = release_hs && sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      word0_q <= '0;
      word1_q <= '0;
    end else if (accept) begin
      if (sel_q) word1_q <= din;
      else       word0_q <= din;
    end else if (release_hs) begin
      sel_q <= ~sel_q;
    end else if (drop) begin
      sel_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {word1_q, word0_q};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign acknowledge = (state_q == ACKED);
  assign vld         = (cnt_q != 2'd0);
  assign dat         = mem_q[rd_ptr_q];
  assign busy        = (state_q != IDLE) || (req_s && en);
  assign lone        = sel_q;

endmodule

// File: rtl/paicore_recv_merge.sv
// Round-robin merge of the PAICORE channels onto one AXI-Stream master with length/timeout tlast.
// FIFO push to tvalid is 1 clk; the output register reloads on the accepting cycle, so no bubble under ready.
module paicore_recv_merge
  import paicore_rx_pkg::*;
#(
  parameter int Channel     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 16
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [Channel-1:0]      ien,
  input  logic                    rx_start,
  input  logic [31:0]             recv_len,
  input  logic [TIMEOUT_W-1:0]    rx_timeout,
  paicore_recv_merge_if.master    bus,
  output logic [31:0]             data_cnt,
  output logic [31:0]             drop_cnt,
  output logic                    o_rx_done
);

  localparam int IDX_W = (Channel > 1) ? $clog2(Channel) : 1;

  logic [Channel-1:0]    ch_vld, ch_pop, ch_busy, ch_lone, ack;
  logic [DATA_WIDTH-1:0] ch_dat [Channel];

  logic [IDX_W-1:0]      last_gnt_q, gnt_idx, cand;
  logic                  gnt_vld;
  logic                  armed_q;
  logic [31:0]           beats_popped_q;
  logic [TIMEOUT_W-1:0]  idle_cnt_q;
  logic                  out_vld_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_dat_q;
  logic                  hs, pop, is_last, idle_cond, tmo_fire;
  logic [31:0]           lone_cnt;

  for (genvar i = 0; i < Channel; i++) begin : g_ch
    paicore_rx_hs_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (ien[i]),
      .request     (bus.request[i]),
      .din         (bus.din[WORD_W*i +: WORD_W]),
      .acknowledge (ack[i]),
      .pop         (ch_pop[i]),
      .drop        (tmo_fire),
      .vld         (ch_vld[i]),
      .dat         (ch_dat[i]),
      .busy        (ch_busy[i]),
      .lone        (ch_lone[i])
    );
  end

  // Descending scan so the nearest channel after the last grant wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = Channel; k >= 1; k--) begin
      cand = IDX_W'((int'(last_gnt_q) + k) % Channel);
      if (ch_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    lone_cnt = '0;
    for (int i = 0; i < Channel; i++) lone_cnt = lone_cnt + {31'd0, ch_lone[i]};
  end

  assign hs        = out_vld_q && bus.m_axis_tready;
  assign pop       = armed_q && !rx_start && gnt_vld && (!out_vld_q || bus.m_axis_tready);
  assign ch_pop    = pop ? (Channel'(1) << gnt_idx) : '0;
  assign is_last   = (recv_len != 32'd0) && (beats_popped_q + 32'd1 == recv_len);
  assign idle_cond = armed_q && (beats_popped_q != 32'd0) && (ch_vld == '0) && !out_vld_q
                     && (ch_busy == '0) && (rx_timeout != '0);
  assign tmo_fire  = idle_cond && !rx_start && (idle_cnt_q == rx_timeout - TIMEOUT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
      last_gnt_q <= IDX_W'(Channel - 1);
    end else if (pop) begin
      out_vld_q  <= 1'b1;
      out_last_q <= is_last;
      out_dat_q  <= ch_dat[gnt_idx];
      last_gnt_q <= gnt_idx;
    end else if (tmo_fire) begin
      out_vld_q  <= 1'b1;
      out_last_q <= 1'b1;
      out_dat_q  <= TERM_BEAT;
    end else if (hs) begin
      out_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q        <= 1'b1;
      beats_popped_q <= '0;
      idle_cnt_q     <= '0;
      data_cnt       <= '0;
      drop_cnt       <= '0;
      o_rx_done      <= 1'b0;
    end else if (rx_start) begin
      // A beat accepted on this cycle already belongs to the new transfer
      armed_q        <= 1'b1;
      beats_popped_q <= '0;
      idle_cnt_q     <= '0;
      data_cnt       <= hs ? 32'd1 : 32'd0;
      drop_cnt       <= '0;
      o_rx_done      <= 1'b0;
    end else begin
      if ((pop && is_last) || tmo_fire) armed_q <= 1'b0;
      if (pop) beats_popped_q <= beats_popped_q + 32'd1;
      if (!idle_cond || tmo_fire) idle_cnt_q <= '0;
      else                        idle_cnt_q <= idle_cnt_q + TIMEOUT_W'(1);
      if (hs) data_cnt <= data_cnt + 32'd1;
      if (tmo_fire) drop_cnt <= drop_cnt + lone_cnt;
      if (hs && out_last_q) o_rx_done <= 1'b1;
    end
  end

  assign bus.acknowledge   = ack;
  assign bus.m_axis_tvalid = out_vld_q;
  assign bus.m_axis_tlast  = out_last_q;
  assign bus.m_axis_tdata  = out_dat_q;

endmodule

// File: tb/tb_paicore_recv_merge.sv
// Directed bench: a table of single-channel transfers plus hand-written merge, backpressure, enable and reset cases.
module tb_paicore_recv_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ien;
  logic        rx_start;
  logic [31:0] recv_len;
  logic [15:0] rx_timeout;
  logic [31:0] data_cnt, drop_cnt;
  logic        o_rx_done;

  logic        req_w [4];
  logic [31:0] din_w [4];
  int          acked [4];
  logic [64:0] got [$];
  logic        ack1_seen;
  int          n_vec = 0;
  int          n_bad = 0;

  localparam logic [64:0] TERM = {1'b1, {64{1'b1}}};

  always #5 clk = ~clk;

  paicore_recv_merge_if #(.Channel(4), .DATA_WIDTH(64)) bus ();

  assign bus.request = {req_w[3], req_w[2], req_w[1], req_w[0]};
  assign bus.din     = {din_w[3], din_w[2], din_w[1], din_w[0]};

  paicore_recv_merge #(.Channel(4), .DATA_WIDTH(64), .SYNC_STAGES(2), .TIMEOUT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ien        (ien),
    .rx_start   (rx_start),
    .recv_len   (recv_len),
    .rx_timeout (rx_timeout),
    .bus        (bus),
    .data_cnt   (data_cnt),
    .drop_cnt   (drop_cnt),
    .o_rx_done  (o_rx_done)
  );

  // Inputs only change just after posedge, so a negedge sample sees the upcoming handshake
  always @(negedge clk) begin
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready)
      got.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
    if (bus.acknowledge[1]) ack1_seen = 1'b1;
  end

  typedef struct packed {
    logic [1:0]        ch;
    logic [2:0]        nw;
    logic [3:0][31:0]  w;
    logic [31:0]       len;
    logic [15:0]       tmo;
    logic [1:0]        nb;
    logic [2:0][64:0]  b;
    logic [31:0]       dcnt;
    logic [31:0]       drop;
    logic              done;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int ch, input logic [31:0] w, output bit ok);
    int t;
    din_w[ch] = w;
    req_w[ch] = 1'b1;
    t = 0;
    while (!bus.acknowledge[ch] && t < 500) begin cyc(1); t++; end
    ok = bus.acknowledge[ch];
    req_w[ch] = 1'b0;
    t = 0;
    while (bus.acknowledge[ch] && t < 500) begin cyc(1); t++; end
  endtask

  task automatic send_seq(input int ch, input logic [31:0] base, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      send_word(ch, base + 32'(k), ok);
      if (!ok) break;
      acked[ch]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    got.delete();
    for (int i = 0; i < 4; i++) acked[i] = 0;
  endtask

  task automatic start_xfer(input logic [31:0] len, input logic [15:0] tmo);
    recv_len   = len;
    rx_timeout = tmo;
    rx_start   = 1'b1;
    cyc(1);
    rx_start   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ien = 4'hF; rx_start = 1'b0; recv_len = '0; rx_timeout = '0;
    bus.m_axis_tready = 1'b1;
    ack1_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin req_w[i] = 1'b0; din_w[i] = '0; acked[i] = 0; end

    tbl[0] = '{ch:2'd0, nw:3'd4, w:{32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000},
               len:32'd2, tmo:16'd0, nb:2'd2,
               b:{65'h0, {1'b1, 32'hA000_0003, 32'hA000_0002}, {1'b0, 32'hA000_0001, 32'hA000_0000}},
               dcnt:32'd2, drop:32'd0, done:1'b1};
    tbl[1] = '{ch:2'd1, nw:3'd3, w:{32'h0, 32'hB100_0002, 32'hB100_0001, 32'hB100_0000},
               len:32'd0, tmo:16'd10, nb:2'd2,
               b:{65'h0, TERM, {1'b0, 32'hB100_0001, 32'hB100_0000}},
               dcnt:32'd2, drop:32'd1, done:1'b1};
    tbl[2] = '{ch:2'd2, nw:3'd4, w:{32'hD200_0003, 32'hD200_0002, 32'hD200_0001, 32'hD200_0000},
               len:32'd1, tmo:16'd0, nb:2'd1,
               b:{65'h0, 65'h0, {1'b1, 32'hD200_0001, 32'hD200_0000}},
               dcnt:32'd1, drop:32'd0, done:1'b1};
    tbl[3] = '{ch:2'd3, nw:3'd2, w:{32'h0, 32'h0, 32'hE300_0001, 32'hE300_0000},
               len:32'd0, tmo:16'd5, nb:2'd2,
               b:{65'h0, TERM, {1'b0, 32'hE300_0001, 32'hE300_0000}},
               dcnt:32'd2, drop:32'd0, done:1'b1};
    tbl[4] = '{ch:2'd2, nw:3'd4, w:{32'hF200_0003, 32'hF200_0002, 32'hF200_0001, 32'hF200_0000},
               len:32'd3, tmo:16'd20, nb:2'd3,
               b:{TERM, {1'b0, 32'hF200_0003, 32'hF200_0002}, {1'b0, 32'hF200_0001, 32'hF200_0000}},
               dcnt:32'd3, drop:32'd0, done:1'b1};
    tbl[5] = '{ch:2'd0, nw:3'd1, w:{32'h0, 32'h0, 32'h0, 32'h9000_0000},
               len:32'd0, tmo:16'd8, nb:2'd0, b:'0,
               dcnt:32'd0, drop:32'd0, done:1'b0};

    // Reset state
    cyc(3);
    check("rst_ack",    65'(bus.acknowledge),   65'h0);
    check("rst_tvalid", 65'(bus.m_axis_tvalid), 65'h0);
    check("rst_tlast",  65'(bus.m_axis_tlast),  65'h0);
    check("rst_tdata",  65'(bus.m_axis_tdata),  65'h0);
    check("rst_dcnt",   65'(data_cnt),          65'h0);
    check("rst_drop",   65'(drop_cnt),          65'h0);
    check("rst_done",   65'(o_rx_done),         65'h0);
    rst = 1'b0;
    cyc(1);

    // Reset in the middle of a ch2 handshake, then a normal transfer
    begin
      int t;
      start_xfer(32'd2, 16'd0);
      din_w[2] = 32'h5555_0000;
      req_w[2] = 1'b1;
      t = 0;
      while (!bus.acknowledge[2] && t < 50) begin cyc(1); t++; end
      check("midrst_ack_up", 65'(bus.acknowledge[2]), 65'h1);
      rst = 1'b1;
      #2;
      check("midrst_ack",    65'(bus.acknowledge),   65'h0);
      check("midrst_tvalid", 65'(bus.m_axis_tvalid), 65'h0);
      check("midrst_dcnt",   65'(data_cnt),          65'h0);
      check("midrst_done",   65'(o_rx_done),         65'h0);
      req_w[2] = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
      got.delete();
      start_xfer(32'd2, 16'd0);
      send_seq(2, 32'h6600_0000, 4);
      cyc(30);
      check("midrst_nbeats", 65'(got.size()), 65'd2);
      check("midrst_beat0", got.size() > 0 ? got[0] : 65'h0, {1'b0, 32'h6600_0001, 32'h6600_0000});
      check("midrst_beat1", got.size() > 1 ? got[1] : 65'h0, {1'b1, 32'h6600_0003, 32'h6600_0002});
      check("midrst_done2", 65'(o_rx_done), 65'h1);
    end

    // Table of single-channel transfers
    for (int v = 0; v < 6; v++) begin
      do_reset();
      start_xfer(tbl[v].len, tbl[v].tmo);
      send_seq(int'(tbl[v].ch), tbl[v].w[0], int'(tbl[v].nw));
      for (int k = 0; k < int'(tbl[v].nw); k++)
        if (tbl[v].w[k] != tbl[v].w[0] + 32'(k)) $display("table word pattern irregular at vector %0d", v);
      cyc(60);
      check($sformatf("v%0d_nbeats", v), 65'(got.size()), 65'(tbl[v].nb));
      for (int k = 0; k < int'(tbl[v].nb); k++)
        check($sformatf("v%0d_beat%0d", v, k), k < got.size() ? got[k] : 65'h0, tbl[v].b[k]);
      check($sformatf("v%0d_dcnt", v), 65'(data_cnt),  65'(tbl[v].dcnt));
      check($sformatf("v%0d_drop", v), 65'(drop_cnt),  65'(tbl[v].drop));
      check($sformatf("v%0d_done", v), 65'(o_rx_done), 65'(tbl[v].done));
    end

    // Four channels push together: grants in channel order, tlast on ch3
    do_reset();
    start_xfer(32'd4, 16'd0);
    fork
      send_seq(0, 32'hC000_0000, 2);
      send_seq(1, 32'hC000_0010, 2);
      send_seq(2, 32'hC000_0020, 2);
      send_seq(3, 32'hC000_0030, 2);
    join
    cyc(20);
    check("rr_nbeats", 65'(got.size()), 65'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_beat%0d", i), i < got.size() ? got[i] : 65'h0,
            {(i == 3), 32'hC000_0001 + 32'(16*i), 32'hC000_0000 + 32'(16*i)});
    check("rr_done", 65'(o_rx_done), 65'h1);
    check("rr_dcnt", 65'(data_cnt),  65'd4);

    // Sink stalled: three beats buffered, seventh word not acknowledged
    do_reset();
    start_xfer(32'd0, 16'd0);
    bus.m_axis_tready = 1'b0;
    fork
      send_seq(0, 32'h7000_0000, 8);
    join_none
    cyc(200);
    check("bp_acked",  65'(acked[0]),            65'd6);
    check("bp_ack_lo", 65'(bus.acknowledge[0]),  65'h0);
    check("bp_tvalid", 65'(bus.m_axis_tvalid),   65'h1);
    check("bp_none",   65'(got.size()),          65'd0);
    bus.m_axis_tready = 1'b1;
    begin
      int t;
      t = 0;
      while (acked[0] < 8 && t < 300) begin cyc(1); t++; end
    end
    cyc(20);
    check("bp_acked_all", 65'(acked[0]),   65'd8);
    check("bp_nbeats",    65'(got.size()), 65'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_beat%0d", i), i < got.size() ? got[i] : 65'h0,
            {1'b0, 32'h7000_0001 + 32'(2*i), 32'h7000_0000 + 32'(2*i)});
    check("bp_dcnt", 65'(data_cnt), 65'd4);

    // Disabled channel never acknowledges
    do_reset();
    start_xfer(32'd0, 16'd0);
    ien = 4'b1101;
    ack1_seen = 1'b0;
    din_w[1] = 32'h1111_1111;
    req_w[1] = 1'b1;
    cyc(50);
    check("ien_ack1",  65'(ack1_seen),  65'h0);
    check("ien_beats", 65'(got.size()), 65'd0);
    req_w[1] = 1'b0;
    ien = 4'hF;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
